// File: rtl/packet_serializer_sdr8.sv
// Packet link transmitter: latches a header plus up to MAX_WORDS payload words per handshake
// and streams them LSB byte first on an 8-bit SDR bus, IDLE_BYTE between packets.
module packet_serializer_sdr8 #(
    parameter int          MAX_WORDS = 4,
    parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_words,
    input  logic [31:0]               in_hdr,
    input  logic [32*MAX_WORDS-1:0]   in_payload,
    output logic [7:0]                ser_out,
    output logic                      ser_sop,
    output logic                      ser_eop,
    output logic                      busy,
    output logic                      err_zero_hdr
);

    localparam logic [2:0] MAX_N = 3'(MAX_WORDS);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t                      r_state;
    logic [MAX_WORDS:0][31:0]    r_words;
    logic [2:0]                  r_nWords;
    logic [2:0]                  r_wordIdx;
    logic [1:0]                  r_byteIdx;

    logic [2:0]                  w_nClamp;
    logic [31:0]                 w_hdrWire;
    logic                        w_accept;
    logic [1:0]                  w_nextByteIdx;
    logic [2:0]                  w_nextWordIdx;
    logic [31:0]                 w_nextWord;
    logic [7:0]                  w_nextByte;
    logic                        w_nextEop;
    logic                        w_unusedHdrBits;

    // The low five header bits are replaced by the word count on the wire.
    assign w_nClamp        = (in_words > MAX_N) ? MAX_N : in_words;
    assign w_hdrWire       = {in_hdr[31:5], 2'b00, w_nClamp};
    assign w_unusedHdrBits = ^in_hdr[4:0];

    assign in_ready = rst_n & ((r_state == ST_IDLE) | ((r_state == ST_SEND) & ser_eop));
    assign w_accept = in_valid & in_ready;

    assign w_nextByteIdx = r_byteIdx + 2'd1;
    assign w_nextWordIdx = (r_byteIdx == 2'd3) ? r_wordIdx + 3'd1 : r_wordIdx;
    assign w_nextEop     = (w_nextWordIdx == r_nWords) && (w_nextByteIdx == 2'd3);

    always_comb begin
        w_nextWord = '0;
        for (int k = 0; k <= MAX_WORDS; k++) begin
            if (w_nextWordIdx == 3'(k)) begin
                w_nextWord = r_words[k];
            end
        end
    end

    assign w_nextByte = w_nextWord[8*w_nextByteIdx +: 8];

    // Outputs are computed one edge ahead so ser_out/sop/eop/busy all leave the same flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_words      <= '0;
            r_nWords     <= '0;
            r_wordIdx    <= '0;
            r_byteIdx    <= '0;
            ser_out      <= IDLE_BYTE;
            ser_sop      <= 1'b0;
            ser_eop      <= 1'b0;
            busy         <= 1'b0;
            err_zero_hdr <= 1'b0;
        end else begin
            err_zero_hdr <= 1'b0;
            if (w_accept) begin
                if (w_hdrWire == '0) begin
                    r_state      <= ST_IDLE;
                    ser_out      <= IDLE_BYTE;
                    ser_sop      <= 1'b0;
                    ser_eop      <= 1'b0;
                    busy         <= 1'b0;
                    err_zero_hdr <= 1'b1;
                end else begin
                    r_state   <= ST_SEND;
                    r_words   <= {in_payload, w_hdrWire};
                    r_nWords  <= w_nClamp;
                    r_wordIdx <= '0;
                    r_byteIdx <= '0;
                    ser_out   <= w_hdrWire[7:0];
                    ser_sop   <= 1'b1;
                    ser_eop   <= 1'b0;
                    busy      <= 1'b1;
                end
            end else if (r_state == ST_SEND) begin
                if (ser_eop) begin
                    r_state <= ST_IDLE;
                    ser_out <= IDLE_BYTE;
                    ser_sop <= 1'b0;
                    ser_eop <= 1'b0;
                    busy    <= 1'b0;
                end else begin
                    r_byteIdx <= w_nextByteIdx;
                    r_wordIdx <= w_nextWordIdx;
                    ser_out   <= w_nextByte;
                    ser_sop   <= 1'b0;
                    ser_eop   <= w_nextEop;
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_serializer_sdr8.sv
// Bench for packet_serializer_sdr8: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a byte-queue model of the wire.
module tb_packet_serializer_sdr8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   in_words = '0;
    logic [31:0]  in_hdr = '0;
    logic [127:0] in_payload = '0;
    logic [7:0]   ser_out;
    logic         ser_sop;
    logic         ser_eop;
    logic         busy;
    logic         err_zero_hdr;

    int errors = 0;
    int checks = 0;

    packet_serializer_sdr8 #(.MAX_WORDS(4), .IDLE_BYTE(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_words(in_words), .in_hdr(in_hdr), .in_payload(in_payload),
        .ser_out(ser_out), .ser_sop(ser_sop), .ser_eop(ser_eop),
        .busy(busy), .err_zero_hdr(err_zero_hdr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wire model: queue front is the byte the DUT should be showing right now.
    typedef struct packed {logic [7:0] b; logic sop; logic eop;} item_t;
    item_t       q[$];
    bit          expErr = 1'b0;
    bit          mRdy;
    int          mN;
    logic [31:0] mH;
    logic [31:0] mWord;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            expErr = 1'b0;
        end else begin
            mRdy   = (q.size() <= 1);
            expErr = 1'b0;
            if (q.size() > 0) void'(q.pop_front());
            if (in_valid && mRdy) begin
                mN = (int'(in_words) > 4) ? 4 : int'(in_words);
                mH = {in_hdr[31:5], 5'(mN)};
                if (mH == 0) begin
                    expErr = 1'b1;
                end else begin
                    for (int w = 0; w <= mN; w++) begin
                        mWord = (w == 0) ? mH : in_payload[32*(w-1) +: 32];
                        for (int b = 0; b < 4; b++)
                            q.push_back({mWord[8*b +: 8], (w == 0 && b == 0), (w == mN && b == 3)});
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_ready", in_ready, 0);
            checkOutput("rst_busy", busy, 0);
        end else begin
            if (q.size() > 0) begin
                checkOutput("m_byte", ser_out, q[0].b);
                checkOutput("m_sop", ser_sop, q[0].sop);
                checkOutput("m_eop", ser_eop, q[0].eop);
                checkOutput("m_busy", busy, 1);
            end else begin
                checkOutput("m_idle", ser_out, 8'h00);
                checkOutput("m_sop", ser_sop, 0);
                checkOutput("m_eop", ser_eop, 0);
                checkOutput("m_busy", busy, 0);
            end
            checkOutput("m_ready", in_ready, (q.size() <= 1));
            checkOutput("m_err", err_zero_hdr, expErr);
        end
    end

    // Offer one packet from a negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [31:0] hdr, input logic [2:0] n, input logic [127:0] pl);
        bit done = 1'b0;
        in_hdr = hdr; in_words = n; in_payload = pl; in_valid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            done = in_ready;
            @(negedge clk);
        end
        in_valid   = 1'b0;
        in_hdr     = $urandom;
        in_words   = 3'($urandom);
        in_payload = {$urandom, $urandom, $urandom, $urandom};
        checkOutput("accept", done, 1);
    endtask

    logic [7:0] t2Exp [12];

    task automatic checkTest2Stream();
        for (int i = 0; i < 12; i++) begin
            checkOutput("t2_byte", ser_out, t2Exp[i]);
            checkOutput("t2_sop", ser_sop, (i == 0));
            checkOutput("t2_eop", ser_eop, (i == 11));
            @(negedge clk);
        end
        checkOutput("t2_after", ser_out, 8'h00);
        checkOutput("t2_after_busy", busy, 0);
    endtask

    localparam logic [127:0] T2_PL = {32'h0, 32'h0, 32'h01020304, 32'hDEADBEEF};

    initial begin
        logic [7:0] t3Exp [8];
        int cnt;
        t2Exp = '{8'h02, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                  8'h04, 8'h03, 8'h02, 8'h01};
        t3Exp = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};

        $display("[TB] reset and idle");
        repeat (3) @(negedge clk);
        checkOutput("rst_ready_lit", in_ready, 0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle_byte", ser_out, 8'h00);
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_ready", in_ready, 1);
        end

        $display("[TB] single packet");
        applyStimulus(32'h1234_5600, 3'd2, T2_PL);
        checkTest2Stream();

        $display("[TB] back-to-back");
        in_hdr = 32'h100; in_words = 3'd0; in_valid = 1'b1;
        @(negedge clk);
        in_hdr = 32'h200;
        for (int i = 0; i < 8; i++) begin
            checkOutput("b2b_byte", ser_out, t3Exp[i]);
            checkOutput("b2b_ready", in_ready, (i == 3 || i == 7));
            @(negedge clk);
            if (i == 3) in_valid = 1'b0;
        end
        checkOutput("b2b_end", busy, 0);

        $display("[TB] zero header");
        applyStimulus(32'h0000_001F, 3'd0, 128'h0);
        checkOutput("zh_err", err_zero_hdr, 1);
        checkOutput("zh_busy", busy, 0);
        checkOutput("zh_byte", ser_out, 8'h00);
        @(negedge clk);
        checkOutput("zh_err_once", err_zero_hdr, 0);
        checkOutput("zh_busy2", busy, 0);

        $display("[TB] clamp");
        applyStimulus(32'hA5A5_A5FF, 3'd7, {$urandom, $urandom, $urandom, $urandom});
        checkOutput("clamp_b0", ser_out, 8'hE4);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("clamp_len", cnt, 20);

        $display("[TB] reset mid-packet");
        applyStimulus(32'h1234_5600, 3'd2, T2_PL);
        repeat (4) @(negedge clk);
        checkOutput("mid_b5", ser_out, 8'hEF);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_byte", ser_out, 8'h00);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_sop", ser_sop, 0);
        checkOutput("mid_rst_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(32'h1234_5600, 3'd2, T2_PL);
        checkTest2Stream();

        $display("[TB] random traffic");
        for (int p = 0; p < 60; p++) begin
            logic [31:0] h;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            h = $urandom;
            if ($urandom_range(0, 5) == 0) h = $urandom & 32'h1F;
            applyStimulus(h, 3'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
        end
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
